// File: rtl/cmd_encoder_if.sv
// Request and command-byte bus of cmd_encoder.
// Handshakes: a transfer occurs on a rising clk edge where valid && ready are both high.
interface cmd_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [7:0]  req_line;
   logic        req_auto;
   logic [15:0] req_data;
   logic [7:0]  cmd_out;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        busy;
   logic        req_error;

   modport master (
      output req_valid, req_op, req_line, req_auto, req_data, cmd_ready,
      input  req_ready, cmd_out, cmd_valid, busy, req_error
   );

   modport slave (
      input  req_valid, req_op, req_line, req_auto, req_data, cmd_ready,
      output req_ready, cmd_out, cmd_valid, busy, req_error
   );
endinterface

// File: rtl/cmd_encoder.sv
// Expands one register-write request into the parser's command byte stream,
// tracking a shadow of the downstream line and capture flags to skip needless prefixes.
module cmd_encoder #(
   parameter int         NUM_INPUTS = 8,
   parameter logic [7:0] IDLE_BYTE  = 8'h0F
) (
   input  logic           clk,
   input  logic           reset,
   cmd_encoder_if.slave   bus,
   output logic [2:0]     dbg_state_o
);
   localparam logic [2:0] ST_IDLE = 3'd0, ST_LINE = 3'd1, ST_PRE = 3'd2,
                          ST_DATA = 3'd3, ST_POST = 3'd4;
   localparam logic [2:0] OP_SET_LINE = 3'd0, OP_SET_CAPTURE = 3'd1, OP_WRITE_IDX = 3'd2,
                          OP_WRITE_LEN = 3'd3, OP_SET_VOLTAGE = 3'd4, OP_SET_TEST = 3'd5,
                          OP_SET_BAUD = 3'd6, OP_CLEAR = 3'd7;
   localparam logic [8:0] NUM_LINES = 9'(NUM_INPUTS);

   logic [2:0]  state_q, state_d, idx_q, idx_d, op_q, op_d;
   logic [7:0]  line_q, line_d, sh_line_q, sh_line_d;
   logic [15:0] data_q, data_d;
   logic        auto_q, auto_d, err_q, err_d;
   logic        sh_valid_q, sh_valid_d, ts_q, ts_d, ext_q, ext_d, int_q, int_d, extra_q, extra_d;

   logic        accept, line_ok, need_line, has_pre, has_data, has_post, last, take;
   logic [2:0]  op_sel, data_last, after_data, after_pre, after_line;
   logic [7:0]  cmd_byte, cap_on, cap_off;

   function automatic logic [1:0] pick2(input logic [7:0] v, input logic [1:0] i);
      case (i)
         2'd0:    pick2 = v[1:0];
         2'd1:    pick2 = v[3:2];
         2'd2:    pick2 = v[5:4];
         default: pick2 = v[7:6];
      endcase
   endfunction

   assign accept  = bus.req_valid && (state_q == ST_IDLE);
   assign line_ok = {1'b0, bus.req_line} < NUM_LINES;
   assign need_line = !sh_valid_q || (bus.req_line != sh_line_q) || (bus.req_op == OP_SET_LINE);

   // Phase lengths come from the live request while idle, from the latched one afterwards.
   assign op_sel   = (state_q == ST_IDLE) ? bus.req_op : op_q;
   assign has_pre  = (op_sel == OP_WRITE_LEN) || ((op_sel == OP_WRITE_IDX) && extra_q);
   assign has_data = (op_sel != OP_SET_LINE);
   assign has_post = (op_sel == OP_WRITE_LEN);
   always_comb begin
      data_last = 3'd0;
      case (op_sel)
         OP_WRITE_IDX, OP_WRITE_LEN:  data_last = 3'd5;
         OP_SET_VOLTAGE, OP_SET_TEST: data_last = 3'd3;
         default:                     data_last = 3'd0;
      endcase
   end
   assign after_data = has_post ? ST_POST : ST_IDLE;
   assign after_pre  = has_data ? ST_DATA : after_data;
   assign after_line = has_pre  ? ST_PRE  : after_pre;

   assign cap_on  = {1'b1, ts_q, ext_q, int_q, 4'hD};
   assign cap_off = {1'b0, ts_q, ext_q, int_q, 4'hD};

   always_comb begin
      cmd_byte = IDLE_BYTE;
      case (state_q)
         ST_LINE: cmd_byte = {idx_q[1:0], pick2(line_q, idx_q[1:0]), 4'h1};
         ST_PRE:  cmd_byte = (op_q == OP_WRITE_LEN) ? cap_on : cap_off;
         ST_POST: cmd_byte = cap_off;
         ST_DATA: begin
            case (op_q)
               OP_SET_CAPTURE: cmd_byte = {1'b0, data_q[2:0], 4'hD};
               OP_WRITE_IDX, OP_WRITE_LEN: begin
                  case (idx_q)
                     3'd0:    cmd_byte = {auto_q, data_q[2:0],   4'b0100};
                     3'd1:    cmd_byte = {auto_q, data_q[5:3],   4'b0101};
                     3'd2:    cmd_byte = {auto_q, data_q[8:6],   4'b0110};
                     3'd3:    cmd_byte = {auto_q, data_q[11:9],  4'b0111};
                     3'd4:    cmd_byte = {auto_q, 1'b0, data_q[13:12], 4'h8};
                     default: cmd_byte = {auto_q, 1'b1, data_q[15:14], 4'h8};
                  endcase
               end
               OP_SET_VOLTAGE: cmd_byte = {idx_q[1:0], pick2(data_q[7:0], idx_q[1:0]), 4'h9};
               OP_SET_TEST: begin
                  case (idx_q[1:0])
                     2'd0:    cmd_byte = {data_q[3:0], 4'hC};
                     2'd1:    cmd_byte = cap_on;
                     2'd2:    cmd_byte = {data_q[7:4], 4'hC};
                     default: cmd_byte = cap_off;
                  endcase
               end
               OP_SET_BAUD: cmd_byte = {data_q[3:0], 4'h3};
               OP_CLEAR:    cmd_byte = 8'h00;
               default:     cmd_byte = IDLE_BYTE;
            endcase
         end
         default: cmd_byte = IDLE_BYTE;
      endcase
   end

   assign take = (state_q != ST_IDLE) && bus.cmd_ready;
   assign last = (state_q == ST_LINE) ? (idx_q == 3'd3) :
                 (state_q == ST_DATA) ? (idx_q == data_last) : 1'b1;

   always_comb begin
      state_d = state_q;  idx_d = idx_q;   op_d = op_q;   line_d = line_q;
      data_d = data_q;    auto_d = auto_q; err_d = 1'b0;
      sh_line_d = sh_line_q; sh_valid_d = sh_valid_q;
      ts_d = ts_q; ext_d = ext_q; int_d = int_q; extra_d = extra_q;
      if (accept) begin
         op_d = bus.req_op; line_d = bus.req_line; data_d = bus.req_data; auto_d = bus.req_auto;
         err_d = !line_ok;
         if (line_ok) begin
            state_d = need_line ? ST_LINE : after_line;
            idx_d   = 3'd0;
         end
      end else if (take) begin
         idx_d = last ? 3'd0 : idx_q + 3'd1;
         case (state_q)
            ST_LINE: if (last) begin
               sh_line_d = line_q; sh_valid_d = 1'b1; state_d = after_line;
            end
            ST_PRE: begin
               extra_d = (op_q == OP_WRITE_LEN); state_d = after_pre;
            end
            ST_DATA: begin
               if (op_q == OP_SET_CAPTURE) begin
                  ts_d = data_q[2]; ext_d = data_q[1]; int_d = data_q[0]; extra_d = 1'b0;
               end
               if (op_q == OP_SET_TEST && idx_q == 3'd1) extra_d = 1'b1;
               if (op_q == OP_SET_TEST && idx_q == 3'd3) extra_d = 1'b0;
               if (last) state_d = after_data;
            end
            default: begin
               extra_d = 1'b0; state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE; idx_q <= 3'd0; op_q <= 3'd0; line_q <= 8'd0;
         data_q <= 16'd0; auto_q <= 1'b0; err_q <= 1'b0;
         sh_line_q <= 8'd0; sh_valid_q <= 1'b0;
         ts_q <= 1'b1; ext_q <= 1'b0; int_q <= 1'b0; extra_q <= 1'b0;
      end else begin
         state_q <= state_d; idx_q <= idx_d; op_q <= op_d; line_q <= line_d;
         data_q <= data_d; auto_q <= auto_d; err_q <= err_d;
         sh_line_q <= sh_line_d; sh_valid_q <= sh_valid_d;
         ts_q <= ts_d; ext_q <= ext_d; int_q <= int_d; extra_q <= extra_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.cmd_valid = (state_q != ST_IDLE);
   assign bus.cmd_out   = cmd_byte;
   assign bus.req_error = err_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_cmd_encoder.sv
// Directed bench for cmd_encoder: hand-computed byte sequences checked with immediate assertions.
module tb_cmd_encoder;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   cmd_encoder_if bus();

   cmd_encoder #(.NUM_INPUTS(8), .IDLE_BYTE(8'h0F)) dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 16'(bus.cmd_valid), 16'h0);
      check({tag, "_out"},   16'(bus.cmd_out),   16'h0F);
      check({tag, "_busy"},  16'(bus.busy),      16'h0);
      check({tag, "_ready"}, 16'(bus.req_ready), 16'h1);
      check({tag, "_state"}, 16'(dbg_state),     16'h0);
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] line, input logic auto_f,
                       input logic [15:0] data);
      @(negedge clk);
      check("req_ready_before_send", 16'(bus.req_ready), 16'h1);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_line = line;
      bus.req_auto = auto_f; bus.req_data = data;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Consumes n bytes against exp_q; holds cmd_ready low for stall_len cycles at byte stall_idx.
   task automatic collect(input string tag, input int n, input int stall_idx, input int stall_len);
      int got = 0;
      int budget = 0;
      int stalled = 0;
      logic [7:0] want;
      while (got < n && budget < 100) begin
         @(negedge clk);
         budget++;
         bus.cmd_ready = !(got == stall_idx && stalled < stall_len);
         want = (exp_q.size() > 0) ? exp_q[0] : 8'h0F;
         check({tag, "_valid"}, 16'(bus.cmd_valid), 16'h1);
         check({tag, "_byte"},  16'(bus.cmd_out),   16'(want));
         check({tag, "_busy"},  16'(bus.busy),      16'h1);
         if (bus.cmd_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            got++;
         end else stalled++;
      end
      bus.cmd_ready = 1'b1;
      if (got < n) check({tag, "_timeout"}, 16'(got), 16'(n));
   endtask

   task automatic run_seq(input string tag, input int n);
      collect(tag, n, -1, 0);
      @(negedge clk);
      check_idle({tag, "_end"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_line = 8'd0;
      bus.req_auto = 1'b0; bus.req_data = 16'd0; bus.cmd_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_err", 16'(bus.req_error), 16'h0);
      reset = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      // WRITE_IDX line 0 auto: full line prefix then six data bytes
      send(3'd2, 8'd0, 1'b1, 16'hA5C3);
      exp_q = {8'h01, 8'h41, 8'h81, 8'hC1, 8'hB4, 8'h85, 8'hF6, 8'hA7, 8'hA8, 8'hE8};
      run_seq("widx", 10);

      // WRITE_LEN same line: no prefix, extra-on/off wrapping
      send(3'd3, 8'd0, 1'b0, 16'h0007);
      exp_q = {8'hCD, 8'h74, 8'h05, 8'h06, 8'h07, 8'h08, 8'h48, 8'h4D};
      run_seq("wlen", 8);

      // Out-of-range line
      send(3'd4, 8'd9, 1'b0, 16'h00E4);
      @(negedge clk);
      check("err_pulse", 16'(bus.req_error), 16'h1);
      check_idle("err_idle");
      @(negedge clk);
      check("err_clear", 16'(bus.req_error), 16'h0);
      check_idle("err_idle2");

      send(3'd4, 8'd0, 1'b0, 16'h00E4);
      exp_q = {8'h09, 8'h59, 8'hA9, 8'hF9};
      run_seq("volt", 4);

      send(3'd5, 8'd0, 1'b0, 16'h003A);
      exp_q = {8'hAC, 8'hCD, 8'h3C, 8'h4D};
      run_seq("test", 4);

      send(3'd5, 8'd0, 1'b0, 16'h003A);
      exp_q = {8'hAC, 8'hCD, 8'h3C, 8'h4D};
      collect("test_stall", 4, 1, 3);
      @(negedge clk);
      check_idle("test_stall_end");

      // Asynchronous reset while the third WRITE_LEN byte is offered
      send(3'd3, 8'd0, 1'b0, 16'h0007);
      exp_q = {8'hCD, 8'h74};
      collect("rst_len", 2, -1, 0);
      @(negedge clk);
      check("rst_len_b3", 16'(bus.cmd_out), 16'h05);
      check("rst_len_v3", 16'(bus.cmd_valid), 16'h1);
      #2 reset = 1'b1;
      #1;
      check_idle("async_rst");
      @(negedge clk);
      reset = 1'b0;

      send(3'd2, 8'd0, 1'b0, 16'h0000);
      exp_q = {8'h01, 8'h41, 8'h81, 8'hC1, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h48};
      run_seq("widx_after_rst", 10);

      send(3'd0, 8'h05, 1'b0, 16'h0000);
      exp_q = {8'h11, 8'h51, 8'h81, 8'hC1};
      run_seq("setline5", 4);

      send(3'd7, 8'h05, 1'b0, 16'hFFFF);
      exp_q = {8'h00};
      run_seq("clear5", 1);

      send(3'd7, 8'h06, 1'b0, 16'h0000);
      exp_q = {8'h21, 8'h51, 8'h81, 8'hC1, 8'h00};
      run_seq("clear6", 5);

      send(3'd1, 8'h06, 1'b0, 16'hFFFA);
      exp_q = {8'h2D};
      run_seq("capture", 1);

      send(3'd6, 8'h06, 1'b0, 16'h1239);
      exp_q = {8'h93};
      run_seq("baud", 1);

      // Capture flags now ts=0 ext=1 int=0
      send(3'd3, 8'h06, 1'b1, 16'h0000);
      exp_q = {8'hAD, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'hC8, 8'h2D};
      run_seq("wlen_flags", 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
